// File: rtl/axi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axi_pkg
// Purpose  : Shared AXI4 encodings for the memory responder: response codes,
//            burst types, write/read FSM states and small decode helpers.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package axi_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_e;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } burst_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_e;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_e;

    // WRAP is not supported, and a beat wider than the bus is meaningless.
    function automatic logic is_proto_err(input logic [1:0] burst,
                                          input logic [2:0] size,
                                          input logic [2:0] max_size);
        return (burst == BURST_WRAP) || (size > max_size);
    endfunction

    // SLVERR outranks DECERR, which outranks OKAY.
    function automatic logic [1:0] resp_code(input logic slv, input logic dec);
        if (slv) return RESP_SLVERR;
        if (dec) return RESP_DECERR;
        return RESP_OKAY;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_burst_address.sv
`default_nettype none
// ============================================================================
// Module   : axi_burst_address
// Purpose  : Per-beat address arithmetic for one AXI burst channel.
// Ports    : addr      - current beat byte address
//            size      - AxSIZE (bytes per beat = 2^size)
//            burst     - AxBURST
//            next_addr - address of the following beat
//            in_range  - current address lies inside the backing memory
//            word_idx  - memory word addressed by the current beat
// Revision : 1.0 - initial release
// ============================================================================
module axi_burst_address
    import axi_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 256,
    parameter int DEPTH      = 64
) (
    input  logic [ADDR_WIDTH-1:0]    addr,
    input  logic [2:0]               size,
    input  logic [1:0]               burst,
    output logic [ADDR_WIDTH-1:0]    next_addr,
    output logic                     in_range,
    output logic [$clog2(DEPTH)-1:0] word_idx
);

    localparam int LANE_BITS = $clog2(DATA_WIDTH / 8);
    localparam int IDX_BITS  = $clog2(DEPTH);
    localparam int SPAN_BITS = LANE_BITS + IDX_BITS;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;

    logic [ADDR_WIDTH-1:0] w_step;
    logic [ADDR_WIDTH-1:0] w_aligned;

    always_comb begin
        w_step    = ADDR_ONE << size;
        w_aligned = addr & ~(w_step - ADDR_ONE);
        // WRAP is rejected upstream; it falls through to INCR here.
        if (burst == BURST_FIXED) begin
            next_addr = addr;
        end else begin
            next_addr = w_aligned + w_step;
        end
    end

    assign in_range = (addr[ADDR_WIDTH-1:SPAN_BITS] == '0);
    assign word_idx = addr[LANE_BITS +: IDX_BITS];

endmodule
`default_nettype wire

// File: rtl/axi_memory_responder.sv
`default_nettype none
// ============================================================================
// Module   : axi_memory_responder
// Purpose  : AXI4 subordinate backed by a flop array. One write burst and one
//            read burst in flight at a time on independent channels; address
//            range and protocol errors are reported through BRESP/RRESP.
// Ports    : data_aclk / data_aresetn - clock, async active-low reset
//            AW/W/B - write address, write data, write response channels
//            AR/R   - read address, read data channels
// Revision : 1.0 - initial release
// ============================================================================
module axi_memory_responder
    import axi_pkg::*;
#(
    parameter int ID_WIDTH   = 24,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 256,
    parameter int DEPTH      = 64
) (
    input  logic                    data_aclk,
    input  logic                    data_aresetn,
    input  logic [ID_WIDTH-1:0]     data_awid,
    input  logic [ADDR_WIDTH-1:0]   data_awaddr,
    input  logic [7:0]              data_awlen,
    input  logic [2:0]              data_awsize,
    input  logic [1:0]              data_awburst,
    input  logic                    data_awvalid,
    output logic                    data_awready,
    input  logic [DATA_WIDTH-1:0]   data_wdata,
    input  logic [DATA_WIDTH/8-1:0] data_wstrb,
    input  logic                    data_wlast,
    input  logic                    data_wvalid,
    output logic                    data_wready,
    output logic [ID_WIDTH-1:0]     data_bid,
    output logic [1:0]              data_bresp,
    output logic                    data_bvalid,
    input  logic                    data_bready,
    input  logic [ID_WIDTH-1:0]     data_arid,
    input  logic [ADDR_WIDTH-1:0]   data_araddr,
    input  logic [7:0]              data_arlen,
    input  logic [2:0]              data_arsize,
    input  logic [1:0]              data_arburst,
    input  logic                    data_arvalid,
    output logic                    data_arready,
    output logic [ID_WIDTH-1:0]     data_rid,
    output logic [DATA_WIDTH-1:0]   data_rdata,
    output logic [1:0]              data_rresp,
    output logic                    data_rlast,
    output logic                    data_rvalid,
    input  logic                    data_rready
);

    localparam int STRB     = DATA_WIDTH / 8;
    localparam int IDX_BITS = $clog2(DEPTH);
    localparam logic [2:0] MAX_SIZE = 3'($clog2(STRB));

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // ------------------------------------------------------------------ write
    wr_state_e             r_wr_state;
    logic [ID_WIDTH-1:0]   r_wr_id;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [7:0]            r_wr_len;
    logic [7:0]            r_wr_beat;
    logic [2:0]            r_wr_size;
    logic [1:0]            r_wr_burst;
    logic                  r_wr_proto_err;
    logic                  r_wr_slv;
    logic                  r_wr_dec;

    logic [ADDR_WIDTH-1:0] w_wr_next;
    logic                  w_wr_in_range;
    logic [IDX_BITS-1:0]   w_wr_idx;
    logic                  w_wr_last;
    logic                  w_wlast_err;

    axi_burst_address #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_wr_addr (
        .addr      (r_wr_addr),
        .size      (r_wr_size),
        .burst     (r_wr_burst),
        .next_addr (w_wr_next),
        .in_range  (w_wr_in_range),
        .word_idx  (w_wr_idx)
    );

    // Burst length comes from awlen alone; wlast is only cross-checked.
    assign w_wr_last   = (r_wr_beat == r_wr_len);
    assign w_wlast_err = (data_wlast != w_wr_last);

    always_ff @(posedge data_aclk or negedge data_aresetn) begin
        if (!data_aresetn) begin
            r_wr_state     <= W_IDLE;
            data_awready   <= 1'b0;
            data_wready    <= 1'b0;
            data_bvalid    <= 1'b0;
            data_bid       <= '0;
            data_bresp     <= '0;
            r_wr_id        <= '0;
            r_wr_addr      <= '0;
            r_wr_len       <= '0;
            r_wr_beat      <= '0;
            r_wr_size      <= '0;
            r_wr_burst     <= '0;
            r_wr_proto_err <= 1'b0;
            r_wr_slv       <= 1'b0;
            r_wr_dec       <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            case (r_wr_state)
                W_IDLE: begin
                    if (data_awready && data_awvalid) begin
                        r_wr_id        <= data_awid;
                        r_wr_addr      <= data_awaddr;
                        r_wr_len       <= data_awlen;
                        r_wr_size      <= data_awsize;
                        r_wr_burst     <= data_awburst;
                        r_wr_proto_err <= is_proto_err(data_awburst, data_awsize, MAX_SIZE);
                        r_wr_beat      <= '0;
                        r_wr_slv       <= 1'b0;
                        r_wr_dec       <= 1'b0;
                        data_awready   <= 1'b0;
                        data_wready    <= 1'b1;
                        r_wr_state     <= W_DATA;
                    end else begin
                        data_awready <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (data_wvalid && data_wready) begin
                        // Protocol-error bursts consume data without touching memory.
                        if (!r_wr_proto_err && w_wr_in_range) begin
                            for (int b = 0; b < STRB; b++) begin
                                if (data_wstrb[b]) begin
                                    r_mem[w_wr_idx][b*8 +: 8] <= data_wdata[b*8 +: 8];
                                end
                            end
                        end
                        r_wr_slv  <= r_wr_slv | w_wlast_err;
                        r_wr_dec  <= r_wr_dec | !w_wr_in_range;
                        r_wr_addr <= w_wr_next;
                        r_wr_beat <= r_wr_beat + 8'd1;
                        if (w_wr_last) begin
                            data_wready <= 1'b0;
                            data_bvalid <= 1'b1;
                            data_bid    <= r_wr_id;
                            data_bresp  <= resp_code(r_wr_proto_err | r_wr_slv | w_wlast_err,
                                                     r_wr_dec | !w_wr_in_range);
                            r_wr_state  <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (data_bready) begin
                        data_bvalid  <= 1'b0;
                        data_awready <= 1'b1;
                        r_wr_state   <= W_IDLE;
                    end
                end
                default: begin
                    r_wr_state <= W_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------- read
    rd_state_e             r_rd_state;
    logic [ADDR_WIDTH-1:0] r_rd_addr;      // address of the next beat to load
    logic [7:0]            r_rd_len;
    logic [7:0]            r_rd_beat;
    logic [2:0]            r_rd_size;
    logic [1:0]            r_rd_burst;
    logic                  r_rd_proto_err;

    logic                  w_rd_idle;
    logic [ADDR_WIDTH-1:0] w_rd_cur_addr;
    logic [2:0]            w_rd_cur_size;
    logic [1:0]            w_rd_cur_burst;
    logic                  w_rd_proto;
    logic [ADDR_WIDTH-1:0] w_rd_next;
    logic                  w_rd_in_range;
    logic [IDX_BITS-1:0]   w_rd_idx;
    logic [DATA_WIDTH-1:0] w_rd_load_data;
    logic [1:0]            w_rd_load_resp;

    // Beat 0 is loaded straight from the AR channel on the handshake edge;
    // later beats come from the latched request.
    always_comb begin
        w_rd_idle      = (r_rd_state == R_IDLE);
        w_rd_cur_addr  = w_rd_idle ? data_araddr  : r_rd_addr;
        w_rd_cur_size  = w_rd_idle ? data_arsize  : r_rd_size;
        w_rd_cur_burst = w_rd_idle ? data_arburst : r_rd_burst;
        w_rd_proto     = w_rd_idle ? is_proto_err(data_arburst, data_arsize, MAX_SIZE)
                                   : r_rd_proto_err;
        w_rd_load_data = '0;
        w_rd_load_resp = resp_code(w_rd_proto, !w_rd_in_range);
        if (!w_rd_proto && w_rd_in_range) begin
            // Registered from the array's pre-edge contents, so a same-edge
            // write to this word is not visible in this beat.
            w_rd_load_data = r_mem[w_rd_idx];
        end
    end

    axi_burst_address #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_rd_addr (
        .addr      (w_rd_cur_addr),
        .size      (w_rd_cur_size),
        .burst     (w_rd_cur_burst),
        .next_addr (w_rd_next),
        .in_range  (w_rd_in_range),
        .word_idx  (w_rd_idx)
    );

    always_ff @(posedge data_aclk or negedge data_aresetn) begin
        if (!data_aresetn) begin
            r_rd_state     <= R_IDLE;
            data_arready   <= 1'b0;
            data_rvalid    <= 1'b0;
            data_rlast     <= 1'b0;
            data_rid       <= '0;
            data_rdata     <= '0;
            data_rresp     <= '0;
            r_rd_addr      <= '0;
            r_rd_len       <= '0;
            r_rd_beat      <= '0;
            r_rd_size      <= '0;
            r_rd_burst     <= '0;
            r_rd_proto_err <= 1'b0;
        end else begin
            case (r_rd_state)
                R_IDLE: begin
                    if (data_arready && data_arvalid) begin
                        data_rid       <= data_arid;
                        r_rd_len       <= data_arlen;
                        r_rd_size      <= data_arsize;
                        r_rd_burst     <= data_arburst;
                        r_rd_proto_err <= w_rd_proto;
                        r_rd_addr      <= w_rd_next;
                        r_rd_beat      <= '0;
                        data_rdata     <= w_rd_load_data;
                        data_rresp     <= w_rd_load_resp;
                        data_rlast     <= (data_arlen == 8'd0);
                        data_rvalid    <= 1'b1;
                        data_arready   <= 1'b0;
                        r_rd_state     <= R_DATA;
                    end else begin
                        data_arready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (data_rvalid && data_rready) begin
                        if (data_rlast) begin
                            data_rvalid  <= 1'b0;
                            data_rlast   <= 1'b0;
                            data_arready <= 1'b1;
                            r_rd_state   <= R_IDLE;
                        end else begin
                            r_rd_beat  <= r_rd_beat + 8'd1;
                            r_rd_addr  <= w_rd_next;
                            data_rdata <= w_rd_load_data;
                            data_rresp <= w_rd_load_resp;
                            data_rlast <= ((r_rd_beat + 8'd1) == r_rd_len);
                        end
                    end
                end
                default: begin
                    r_rd_state <= R_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/axi_memory_responder.md
Name: axi_memory_responder

Overview:
- AXI4 subordinate backed by a flop array; the far-end target for the injector's AXI data output.
- Used in block and system benches, and as a scratch RAM for loopback bring-up.
- Accepts one write burst and one read burst at a time, on independent channels.
- Reports address-range and protocol errors through BRESP/RRESP.

Parameters:
ID_WIDTH, 24, width of AXI ID fields
ADDR_WIDTH, 32, width of AXI address
DATA_WIDTH, 256, data bus width in bits (power of two, ≥ 32); STRB = DATA_WIDTH/8
DEPTH, 64, number of DATA_WIDTH words (power of two); byte range 0 .. DEPTH*STRB-1

Ports (one line per AXI channel; direction and width for each signal):
data_aclk in 1 clock; data_aresetn in 1 asynchronous active-low reset
AW: data_awid in ID_WIDTH, data_awaddr in ADDR_WIDTH, data_awlen in 8, data_awsize in 3, data_awburst in 2, data_awvalid in 1, data_awready out 1
W: data_wdata in DATA_WIDTH, data_wstrb in STRB, data_wlast in 1, data_wvalid in 1, data_wready out 1
B: data_bid out ID_WIDTH, data_bresp out 2, data_bvalid out 1, data_bready in 1
AR: data_arid in ID_WIDTH, data_araddr in ADDR_WIDTH, data_arlen in 8, data_arsize in 3, data_arburst in 2, data_arvalid in 1, data_arready out 1
R: data_rid out ID_WIDTH, data_rdata out DATA_WIDTH, data_rresp out 2, data_rlast out 1, data_rvalid out 1, data_rready in 1

Behaviour:
- Clock and reset: one clock, data_aclk. Reset is asynchronous and active-low on data_aresetn.
- Reset values:
  - All outputs 0, including awready and arready.
  - Memory cleared to 0.
  - awready and arready rise on the first data_aclk edge after reset deassertion.
- Reset mid-burst: aborts the burst silently. No response is issued, and words already written keep their new value until the reset clears them.
- Write FSM, states W_IDLE → W_DATA → W_RESP:
  - W_IDLE: awready=1. On AW handshake, latch id/addr/len/size/burst and go to W_DATA.
  - W_DATA: wready=1 from the next cycle.
  - Each W handshake writes strobed bytes to mem[addr[log2(STRB) +: log2(DEPTH)]] at that edge and advances the beat counter.
  - Beat awlen ends the burst and moves to W_RESP.
  - W_RESP: bvalid=1 and bid=latched id, held until bready. Then W_IDLE with awready=1 the next cycle.
- Read FSM, states R_IDLE → R_DATA:
  - R_IDLE: arready=1. On AR handshake, latch the request and register beat-0 data. rvalid=1 the next cycle.
  - R_DATA: rdata/rresp/rlast are registered and stable while rvalid && !rready.
  - Each R handshake loads the next beat's data.
  - rlast=1 on beat arlen. Its handshake returns to R_IDLE, with arready=1 the next cycle.
- Address sequencing, per beat:
  - FIXED: address constant.
  - INCR: next = align(addr, size) + 2^size. No 4 KB boundary check.
  - Narrow sizes are permitted; the full word is read and written, with lanes selected by wstrb only.
- Errors (response codes: OKAY=0, SLVERR=2, DECERR=3):
  - WRAP burst, or size > log2(STRB): SLVERR.
    - Writes: data is consumed, no memory update.
    - Reads: every beat returns data 0 with SLVERR.
  - Beat address ≥ DEPTH*STRB: DECERR for that beat.
    - Writes: the beat is dropped.
    - Reads: the beat returns data 0.
  - wlast mismatch (wlast=1 before beat awlen, or wlast=0 on beat awlen): sets a sticky SLVERR. Burst length is always taken from awlen, never from wlast.
  - BRESP precedence: SLVERR > DECERR > OKAY, accumulated over all beats.
- Read/write collision: a read-data load and a write to the same word at the same edge returns the pre-write value.
- Both FSMs run fully in parallel. awvalid/arvalid held while busy simply wait.
- Length arithmetic: 8-bit counter compared to the latched len. len=255 gives 256 beats with no overflow.

Decomposition:
- Shared package axi_pkg:
  - Response codes OKAY/EXOKAY/SLVERR/DECERR.
  - Burst codes FIXED/INCR/WRAP.
  - Write and read FSM state enums.
- Sub-module axi_burst_address: computes next address, in-range flag and word index from (addr, size, burst). Instantiated once for the write path and once for the read path.

Test Plan:
1. Reset, then AW id=0x12 addr=0x40 len=3 size=5 INCR, 4 beats full strobe → wready asserted 1 cycle after AW; words 2..5 written; bvalid 1 cycle after the last beat, bid=0x12, bresp=OKAY.
2. AR id=0x7 addr=0x40 len=3 INCR after test 1 → rvalid 1 cycle after AR; 4 beats match the written data; rlast on beat 3 only; rdata stable across 3 cycles of rready=0 stall.
3. Write addr=0x7E0 len=1 (beat 1 out of range at 0x800) → word 63 written, beat 1 dropped, bresp=DECERR; read of same range → rresp OKAY then DECERR with data 0.
4. awburst=WRAP and, separately, wlast=1 on beat 0 of len=2 → bresp=SLVERR for both; memory unchanged for WRAP; exactly 3 beats accepted for the len=2 case.
5. Same-cycle R beat load and W handshake to word 5 → read returns old value; a re-read returns the new value.
6. Assert data_aresetn low mid-burst (beat 2 of 4) → all outputs 0 immediately, no bvalid afterwards, memory reads 0, awready=1 one edge after release.
